// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control FSM: Moore datapath controls per state,
// memory-ready handshaking and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int USE_MEM_READY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic [3:0]  state,
    output logic        instr_done,
    output logic        illegal,
    output logic [31:0] instret
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] RWB    = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;
    localparam logic [3:0] ADDIEX = 4'd10;
    localparam logic [3:0] ADDIWB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    logic [3:0]  r_state;
    logic [31:0] r_instret;
    logic [3:0]  w_next;
    logic        w_rdy;
    logic        w_pc_write, w_pc_write_cond, w_mem_read, w_mem_write;
    logic        w_ir_write, w_reg_write, w_done, w_illegal;

    assign w_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_comb begin
        w_next = FETCH;
        case (r_state)
            FETCH:  w_next = w_rdy ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:      w_next = EXEC;
                    OP_LW, OP_SW:  w_next = MEMADR;
                    OP_BEQ:        w_next = BRANCH;
                    OP_J:          w_next = JUMP;
                    OP_ADDI:       w_next = ADDIEX;
                    default:       w_next = FETCH;
                endcase
            end
            MEMADR: w_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  w_next = w_rdy ? MEMWB : MEMRD;
            MEMWR:  w_next = w_rdy ? FETCH : MEMWR;
            EXEC:   w_next = RWB;
            ADDIEX: w_next = ADDIWB;
            default: w_next = FETCH;
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_done          = 1'b0;
        w_illegal       = 1'b0;
        i_or_d          = 1'b0;
        mem_to_reg      = 1'b0;
        reg_dst         = 1'b0;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        alu_op          = 2'b00;
        pc_source       = 2'b00;
        case (r_state)
            FETCH: begin
                w_mem_read = 1'b1;
                alu_src_b  = 2'b01;
                // IR/PC only capture on the cycle the fetch actually completes
                w_ir_write = w_rdy;
                w_pc_write = w_rdy;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                w_illegal = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
            end
            MEMADR, ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            MEMRD: begin
                w_mem_read = 1'b1;
                i_or_d     = 1'b1;
            end
            MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            MEMWR: begin
                w_mem_write = 1'b1;
                i_or_d      = 1'b1;
                w_done      = w_rdy;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            RWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            BRANCH: begin
                alu_src_a       = 1'b1;
                alu_op          = 2'b01;
                w_pc_write_cond = 1'b1;
                pc_source       = 2'b01;
                w_done          = 1'b1;
            end
            JUMP: begin
                w_pc_write = 1'b1;
                pc_source  = 2'b10;
                w_done     = 1'b1;
            end
            ADDIWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            default: ;
        endcase
    end

    // State-changing strobes are squashed during reset so nothing escapes mid-reset
    assign pc_write      = w_pc_write      & ~rst;
    assign pc_write_cond = w_pc_write_cond & ~rst;
    assign mem_read      = w_mem_read      & ~rst;
    assign mem_write     = w_mem_write     & ~rst;
    assign ir_write      = w_ir_write      & ~rst;
    assign reg_write     = w_reg_write     & ~rst;
    assign instr_done    = w_done          & ~rst;
    assign illegal       = w_illegal       & ~rst;
    assign state         = r_state;
    assign instret       = r_instret;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_done)
                r_instret <= r_instret + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations are queued by
// the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic        instr_done, illegal;
    logic [31:0] instret;

    multicycle_ctrl #(.USE_MEM_READY(1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .instr_done(instr_done),
        .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        done;
        logic        ill;
        logic [31:0] ir;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] act_ctl;
    assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // Hand-entered control table, same field order as act_ctl
    function automatic logic [15:0] ectl(input logic [3:0] s, input logic rdy, input logic r);
        logic pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, ps;
        {pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (s)
            4'd0:  begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
            4'd1:  asb = 2'b11;
            4'd2, 4'd10: begin asa = 1; asb = 2'b10; end
            4'd3:  begin mr = 1; iod = 1; end
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin mw = 1; iod = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
            4'd9:  begin pcw = 1; ps = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        if (r) {pcw, pwc, irw, rw, mw, mr} = '0;
        return {pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, ps};
    endfunction

    // Drive one cycle's inputs and queue what the DUT must show during that cycle
    task automatic step(input logic [3:0] s, input logic rdy, input logic [5:0] op,
                        input logic r, input logic done, input logic ill, input logic [31:0] ir);
        exp_t e;
        rst = r; mem_ready = rdy; opcode = op;
        e.st = s; e.ctl = ectl(s, rdy, r); e.done = done; e.ill = ill; e.ir = ir;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp += 5;
            if (state !== e.st) begin
                n_err++; $display("FAIL state: got %0d want %0d at %0t", state, e.st, $time);
            end
            if (act_ctl !== e.ctl) begin
                n_err++; $display("FAIL ctl: got %b want %b (state %0d) at %0t", act_ctl, e.ctl, e.st, $time);
            end
            if (instr_done !== e.done) begin
                n_err++; $display("FAIL instr_done: got %b want %b at %0t", instr_done, e.done, $time);
            end
            if (illegal !== e.ill) begin
                n_err++; $display("FAIL illegal: got %b want %b at %0t", illegal, e.ill, $time);
            end
            if (instret !== e.ir) begin
                n_err++; $display("FAIL instret: got %h want %h at %0t", instret, e.ir, $time);
            end
        end
    end

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    initial begin
        rst = 1'b1; mem_ready = 1'b1; opcode = RT;
        @(posedge clk); #1;
        // reset held: FETCH with strobes squashed
        step(4'd0, 1'b1, RT, 1'b1, 1'b0, 1'b0, 32'd0);
        // R-type: 0,1,6,7,0
        step(4'd0, 1'b1, RT, 1'b0, 1'b0, 1'b0, 32'd0);
        step(4'd1, 1'b1, RT, 1'b0, 1'b0, 1'b0, 32'd0);
        step(4'd6, 1'b1, LW, 1'b0, 1'b0, 1'b0, 32'd0);
        step(4'd7, 1'b1, LW, 1'b0, 1'b1, 1'b0, 32'd0);
        // FETCH stalled twice, then illegal opcode
        step(4'd0, 1'b0, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd0, 1'b0, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd0, 1'b1, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd1, 1'b1, BAD, 1'b0, 1'b0, 1'b1, 32'd1);
        // lw with 3 not-ready cycles in MEMRD; opcode churn there is ignored
        step(4'd0, 1'b1, BAD, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd1, 1'b1, LW, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd2, 1'b1, LW, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd3, 1'b0, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd3, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd3, 1'b0, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd3, 1'b1, RT, 1'b0, 1'b0, 1'b0, 32'd1);
        step(4'd4, 1'b1, RT, 1'b0, 1'b1, 1'b0, 32'd1);
        // sw with one not-ready cycle; done only on the ready cycle
        step(4'd0, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd2);
        step(4'd1, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd2);
        step(4'd2, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd2);
        step(4'd5, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'd2);
        step(4'd5, 1'b1, SW, 1'b0, 1'b1, 1'b0, 32'd2);
        // addi
        step(4'd0, 1'b1, ADDI, 1'b0, 1'b0, 1'b0, 32'd3);
        step(4'd1, 1'b1, ADDI, 1'b0, 1'b0, 1'b0, 32'd3);
        step(4'd10, 1'b1, ADDI, 1'b0, 1'b0, 1'b0, 32'd3);
        step(4'd11, 1'b1, ADDI, 1'b0, 1'b1, 1'b0, 32'd3);
        // jump
        step(4'd0, 1'b1, J, 1'b0, 1'b0, 1'b0, 32'd4);
        step(4'd1, 1'b1, J, 1'b0, 1'b0, 1'b0, 32'd4);
        step(4'd9, 1'b1, J, 1'b0, 1'b1, 1'b0, 32'd4);
        // reset asserted in MEMWR: strobes and done squashed, counter cleared
        step(4'd0, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd5);
        step(4'd1, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd5);
        step(4'd2, 1'b1, SW, 1'b0, 1'b0, 1'b0, 32'd5);
        step(4'd5, 1'b0, SW, 1'b0, 1'b0, 1'b0, 32'd5);
        step(4'd5, 1'b1, SW, 1'b1, 1'b0, 1'b0, 32'd5);
        step(4'd0, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 32'd0);
        step(4'd1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 32'd0);
        step(4'd8, 1'b1, BEQ, 1'b0, 1'b1, 1'b0, 32'd0);
        // preload counter to all-ones, then beq retires and wraps it
        force dut.r_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        step(4'd0, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step(4'd1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        step(4'd8, 1'b1, BEQ, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        step(4'd0, 1'b1, RT, 1'b0, 1'b0, 1'b0, 32'd0);
        @(posedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++; $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter USE_MEM_READY, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
REQ-002 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port opcode  input  6  instruction bits 31..26 from the instruction register.
REQ-005 SHALL have port mem_ready  input  1  memory completes the current read or write this cycle.
REQ-006 SHALL have ports pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a  output  1 each  datapath controls.
REQ-007 SHALL have ports alu_src_b, alu_op, pc_source  output  2 each  mux and ALU-function selects.
REQ-008 SHALL have port state  output  4  current state encoding.
REQ-009 SHALL have ports instr_done, illegal  output  1 each  single-cycle status pulses.
REQ-010 SHALL have port instret  output  32  retired-instruction count.

Function
REQ-011 SHALL use the state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; encodings 12..15 SHALL go to FETCH on the next edge.
REQ-012 SHALL make all controls Moore functions of state (except the gating in REQ-015); any control not listed for a state SHALL be 0.
REQ-013 SHALL drive per-state controls:
- FETCH: mem_read=1, alu_src_b=01, pc_source=00.
- DECODE: alu_src_b=11.
- MEMADR, ADDIEX: alu_src_a=1, alu_src_b=10.
- MEMRD: mem_read=1, i_or_d=1.
- MEMWB: mem_to_reg=1, reg_write=1.
- MEMWR: mem_write=1, i_or_d=1.
- EXEC: alu_src_a=1, alu_op=10.
- RWB: reg_dst=1, reg_write=1.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- ADDIWB: reg_write=1.
REQ-014 SHALL apply these transitions:
- FETCH->DECODE.
- DECODE by opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100->BRANCH; 000010->JUMP; 001000->ADDIEX; any other opcode->FETCH.
- MEMADR->MEMRD if opcode=100011, else MEMWR.
- MEMRD->MEMWB.
- EXEC->RWB.
- ADDIEX->ADDIWB.
- MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB->FETCH.
REQ-015 SHALL hold FETCH, MEMRD and MEMWR while effective mem_ready=0, keeping mem_read/mem_write asserted; in FETCH, ir_write and pc_write SHALL be 1 only in the cycle effective mem_ready=1.
REQ-016 SHALL advance out of FETCH, MEMRD or MEMWR only on a cycle with effective mem_ready=1.
REQ-017 SHALL assert instr_done for exactly one cycle in each of MEMWB, RWB, BRANCH, JUMP and ADDIWB; in MEMWR it SHALL be asserted only in the cycle mem_ready=1.
REQ-018 SHALL assert illegal for one cycle in DECODE when the opcode is unrecognised; instr_done SHALL stay 0 and instret SHALL not increment for that instruction.
REQ-019 SHALL increment instret by 1 on each edge where instr_done=1, wrapping from 0xFFFFFFFF to 0.
REQ-020 SHALL sample opcode only in DECODE and MEMADR; opcode changes in other states SHALL have no effect.

Reset
REQ-021 SHALL, on a rising edge with rst=1, set state=FETCH and instret=0, regardless of the current state, including mid-wait in MEMRD or MEMWR.
REQ-022 SHALL force pc_write, pc_write_cond, ir_write, reg_write, mem_write, mem_read, instr_done and illegal to 0 combinationally while rst=1.
REQ-023 SHALL present FETCH controls on the first cycle after rst falls.

Verification
REQ-024 SHALL cover: USE_MEM_READY=1, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; instr_done only in RWB; instret 0->1.
REQ-025 SHALL cover: lw (100011) with mem_ready low for 3 cycles in MEMRD -> state 3 held for 4 cycles with mem_read=1 and i_or_d=1, then MEMWB asserting reg_write=1 and mem_to_reg=1.
REQ-026 SHALL cover: opcode=111111 -> illegal=1 in DECODE, next state 0, instret unchanged.
REQ-027 SHALL cover: FETCH with mem_ready=0 for 2 cycles -> ir_write=0 and pc_write=0 for those cycles, both 1 in the ready cycle, then DECODE.
REQ-028 SHALL cover: rst=1 asserted while in MEMWR -> mem_write=0 immediately, state=0 and instret=0 after the edge.
REQ-029 SHALL cover: instret preloaded via 0xFFFFFFFF retirements, or a forced value, then beq (000100) -> pc_write_cond=1, pc_source=01, instret wraps to 0.
